regfile_wr_scheduler: RTL and testbench

//  Owns the single write port of the 32x32 register file (write/wrReg/wrData).

---
 rtl/regfile_wr_scheduler.sv | 149 ++++++++++++++
 tb/tb_regfile_wr_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wr_scheduler
//   Owns the single write port of the register file. Two writeback requesters
//   are arbitrated round-robin over valid/ready. A bulk-clear sequence
//   zeroes every register, one per cycle.
//
//   Optional build macro: ZERO_REG_PROTECT_EN
//     defined     : a transfer to address 0 still handshakes and moves the
//                   priority, but no write is issued (r0 stays zero). The
//                   clear sequence still writes register 0.
//     not defined : address 0 is written like any other address.
//
// Ports
//   clock                  clock, all state updates on posedge
//   reset                  synchronous, active-high
//   req0_valid/addr/data   requester 0 write request
//   req0_ready             requester 0 accepted this cycle (combinational)
//   req1_valid/addr/data   requester 1 write request
//   req1_ready             requester 1 accepted this cycle (combinational)
//   clr_start              start bulk clear (sampled in IDLE only)
//   clr_busy               high while the clear sequence runs
//   clr_done               one-cycle pulse alongside the final clear write
//   write/wrReg/wrData     registered register file write port
// ---------------------------------------------------------------------------
module regfile_wr_scheduler #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              write,
   output logic [ADDR_W-1:0] wrReg,
   output logic [DATA_W-1:0] wrData
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

   state_t            r_state, w_state_next;
   logic              r_prio, w_prio_next;
   logic [ADDR_W-1:0] r_cnt, w_cnt_next;
   logic              r_write, w_write_next;
   logic [ADDR_W-1:0] r_wrReg, w_wrReg_next;
   logic [DATA_W-1:0] r_wrData, w_wrData_next;
   logic              r_clr_done, w_clr_done_next;

   logic              w_grant0, w_grant1;
   logic              w_accept_ok;
   logic              w_xfer0, w_xfer1;

   // Requester N wins when it is the only one valid, or both are valid and
   // the priority pointer favours it.
   assign w_grant0    = req0_valid & (~req1_valid | ~r_prio);
   assign w_grant1    = req1_valid & ( ~req0_valid | r_prio);
   assign w_accept_ok = (r_state == IDLE) & ~clr_start & ~reset;

   assign req0_ready  = w_accept_ok & w_grant0;
   assign req1_ready  = w_accept_ok & w_grant1;
   assign w_xfer0     = req0_valid & req0_ready;
   assign w_xfer1     = req1_valid & req1_ready;

   always_comb begin
      w_state_next    = r_state;
      w_prio_next     = r_prio;
      w_cnt_next      = r_cnt;
      w_write_next    = 1'b0;
      w_wrReg_next    = r_wrReg;
      w_wrData_next   = r_wrData;
      w_clr_done_next = 1'b0;

      case (r_state)
         IDLE: begin
            if (clr_start) begin
               w_state_next = CLEAR;
               w_cnt_next   = '0;
            end else if (w_xfer0) begin
`ifdef ZERO_REG_PROTECT_EN
               w_write_next  = (req0_addr != '0);
`else
               w_write_next  = 1'b1;
`endif
               w_wrReg_next  = req0_addr;
               w_wrData_next = req0_data;
               w_prio_next   = 1'b1;
            end else if (w_xfer1) begin
`ifdef ZERO_REG_PROTECT_EN
               w_write_next  = (req1_addr != '0);
`else
               w_write_next  = 1'b1;
`endif
               w_wrReg_next  = req1_addr;
               w_wrData_next = req1_data;
               w_prio_next   = 1'b0;
            end
         end
         CLEAR: begin
            w_write_next  = 1'b1;
            w_wrReg_next  = r_cnt;
            w_wrData_next = '0;
            w_cnt_next    = r_cnt + ADDR_W'(1);
            if (r_cnt == LAST_REG) begin
               w_clr_done_next = 1'b1;
               w_state_next    = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_prio     <= 1'b0;
         r_cnt      <= '0;
         r_write    <= 1'b0;
         r_wrReg    <= '0;
         r_wrData   <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_prio     <= w_prio_next;
         r_cnt      <= w_cnt_next;
         r_write    <= w_write_next;
         r_wrReg    <= w_wrReg_next;
         r_wrData   <= w_wrData_next;
         r_clr_done <= w_clr_done_next;
      end
   end

   assign clr_busy = (r_state == CLEAR);
   assign clr_done = r_clr_done;
   assign write    = r_write;
   assign wrReg    = r_wrReg;
   assign wrData   = r_wrData;

endmodule

// File: tb/tb_regfile_wr_scheduler.sv
module tb_regfile_wr_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        clr_start, clr_busy, clr_done;
   logic        write;
   logic [4:0]  wrReg;
   logic [31:0] wrData;

   regfile_wr_scheduler #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .write(write), .wrReg(wrReg), .wrData(wrData)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v0; logic [4:0] a0; logic [31:0] d0;
      logic        v1; logic [4:0] a1; logic [31:0] d1;
      logic        rdy0; logic rdy1;
   } vec_t;

   typedef struct {
      logic        we; logic [4:0] addr; logic [31:0] data;
   } wr_t;

   vec_t vecs[$];
   wr_t  sb[$];
   int   n_vec = 0;
   int   n_err = 0;

`ifdef ZERO_REG_PROTECT_EN
   localparam bit PROTECT = 1'b1;
`else
   localparam bit PROTECT = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.we = we; e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   // Advance one clock; the write port must show the oldest scoreboard entry.
   task automatic step();
      wr_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = sb.pop_front();
         chk("write", {31'd0, write}, {31'd0, e.we});
         if (e.we) begin
            chk("wrReg", {27'd0, wrReg}, {27'd0, e.addr});
            chk("wrData", wrData, e.data);
         end
      end
   endtask

   task automatic drive(input vec_t v);
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
   endtask

   function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic r0, input logic r1);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.rdy0 = r0; v.rdy1 = r1;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      // Priority starts at req0 after reset; each row lists the expected grant.
      vecs.push_back(mk(1, 5'd1, 32'd10, 1, 5'd2, 32'd20, 1, 0));
      vecs.push_back(mk(1, 5'd1, 32'd10, 1, 5'd2, 32'd20, 0, 1));
      vecs.push_back(mk(1, 5'd1, 32'd10, 1, 5'd2, 32'd20, 1, 0));
      vecs.push_back(mk(1, 5'd1, 32'd10, 1, 5'd2, 32'd20, 0, 1));
      vecs.push_back(mk(1, 5'd5, 32'd50, 0, 5'd0, 32'd0,  1, 0));
      vecs.push_back(mk(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,  0, 0));
      vecs.push_back(mk(0, 5'd0, 32'd0,  1, 5'd3, 32'd30, 0, 1));
      vecs.push_back(mk(1, 5'd0, 32'd7,  0, 5'd0, 32'd0,  1, 0));
      vecs.push_back(mk(1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 0, 1));
      vecs.push_back(mk(1, 5'd1, 32'd11, 1, 5'd2, 32'd22, 1, 0));
      vecs.push_back(mk(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,  0, 0));

      // Reset with requests pending: readys must stay low.
      reset = 1'b1; clr_start = 1'b0;
      drive(mk(1, 5'd9, 32'd99, 1, 5'd8, 32'd88, 0, 0));
      @(posedge clock); @(posedge clock); #1;
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_wrReg", {27'd0, wrReg}, 32'd0);
      chk("rst_wrData", wrData, 32'd0);
      chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
      chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      reset = 1'b0;

      // Table-driven arbitration vectors.
      for (int unsigned i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v);
         #1;
         chk($sformatf("ready0_v%0d", i), {31'd0, req0_ready}, {31'd0, v.rdy0});
         chk($sformatf("ready1_v%0d", i), {31'd0, req1_ready}, {31'd0, v.rdy1});
         if (v.v0 && v.rdy0)
            push(!(PROTECT && v.a0 == 5'd0), v.a0, v.d0);
         else if (v.v1 && v.rdy1)
            push(!(PROTECT && v.a1 == 5'd0), v.a1, v.d1);
         else
            push(1'b0, 5'd0, 32'd0);
         step();
      end

      // Bulk clear: clear wins over a pending request, which waits it out.
      drive(mk(1, 5'd4, 32'd40, 1, 5'd3, 32'd30, 0, 0));
      clr_start = 1'b1;
      #1;
      chk("clr_start_ready0", {31'd0, req0_ready}, 32'd0);
      chk("clr_start_ready1", {31'd0, req1_ready}, 32'd0);
      push(1'b0, 5'd0, 32'd0);
      step();
      clr_start = 1'b0;
      req0_valid = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         clr_start = (i == 5);   // ignored while clearing
         #1;
         chk("clr_busy_in", {31'd0, clr_busy}, 32'd1);
         chk("clr_ready1", {31'd0, req1_ready}, 32'd0);
         push(1'b1, 5'(i), 32'd0);
         step();
         chk($sformatf("clr_done_%0d", i), {31'd0, clr_done}, {31'd0, (i == 31)});
         chk($sformatf("clr_busy_%0d", i), {31'd0, clr_busy}, {31'd0, (i != 31)});
      end
      clr_start = 1'b0;
      #1;
      chk("post_clr_ready1", {31'd0, req1_ready}, 32'd1);
      push(1'b1, 5'd3, 32'd30);
      step();
      chk("post_clr_done_low", {31'd0, clr_done}, 32'd0);
      req1_valid = 1'b0;
      push(1'b0, 5'd0, 32'd0);
      step();

      // Reset aborts a clear in progress.
      clr_start = 1'b1;
      push(1'b0, 5'd0, 32'd0);
      step();
      clr_start = 1'b0;
      for (int unsigned i = 0; i <= 10; i++) begin
         push(1'b1, 5'(i), 32'd0);
         step();
      end
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'd60;
      #1;
      chk("rst_mid_ready0", {31'd0, req0_ready}, 32'd0);
      push(1'b0, 5'd0, 32'd0);
      step();
      chk("abort_busy", {31'd0, clr_busy}, 32'd0);
      chk("abort_done", {31'd0, clr_done}, 32'd0);
      reset = 1'b0;
      req0_valid = 1'b0;
      push(1'b0, 5'd0, 32'd0);
      step();
      chk("abort_busy2", {31'd0, clr_busy}, 32'd0);
      chk("abort_done2", {31'd0, clr_done}, 32'd0);

      if (sb.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
